// File: rtl/div_host_if.sv
// Valid/ready front-end for the shift-subtract divider: launches the divider with a
// level go, captures its result on fin and measures the run latency.
module div_host_if #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          div_go,
  output logic [W-1:0]  div_a,
  output logic [W-1:0]  div_b,
  input  logic          div_fin,
  input  logic [W-1:0]  div_q,
  input  logic [W-1:0]  div_r,
  input  logic          div_err,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_q,
  output logic [W-1:0]  out_r,
  output logic          out_err,
  output logic [CW-1:0] out_cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // Saturating increment: a runaway divider must not wrap the latency to a small value.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  // Handshake outputs decode the registered state only, so no input reaches them.
  assign in_ready  = (state == IDLE);
  assign div_go    = (state == RUN);
  assign out_valid = (state == OUT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_a      <= '0;
      div_b      <= '0;
      cnt        <= '0;
      out_q      <= '0;
      out_r      <= '0;
      out_err    <= 1'b0;
      out_cycles <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        div_a <= in_a;
        div_b <= in_b;
        cnt   <= '0;
      end
      if (state == RUN) begin
        if (div_fin) begin
          out_q      <= div_q;
          out_r      <= div_r;
          out_err    <= div_err;
          out_cycles <= cnt_inc;
        end else begin
          cnt <= cnt_inc;
        end
      end
    end
  end

  // NOTE: next state is defaulted before the case so no path through this block
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (div_fin)   state_nxt = DRAIN;
      DRAIN:   if (!div_fin)  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_div_host_if.sv
// Self-checking bench for div_host_if: a divider stub with programmable latency and
// fin hold, a table of operations, a result scoreboard and hand-written corner cases.
module tb_div_host_if;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic       div_go, div_fin, div_err;
  logic [7:0] div_a, div_b, div_q, div_r;
  logic       out_valid, out_ready, out_err;
  logic [7:0] out_q, out_r, out_cycles;

  // Narrow-counter instance fed by the same stub, used for saturation.
  logic       s_in_ready, s_div_go, s_out_valid, s_out_err;
  logic [7:0] s_div_a, s_div_b, s_out_q, s_out_r;
  logic [3:0] s_out_cycles;

  always #5 clk = ~clk;

  div_host_if #(.W(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .div_go(div_go), .div_a(div_a), .div_b(div_b),
    .div_fin(div_fin), .div_q(div_q), .div_r(div_r), .div_err(div_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
    .out_err(out_err), .out_cycles(out_cycles)
  );

  div_host_if #(.W(8), .CW(4)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .div_go(s_div_go), .div_a(s_div_a), .div_b(s_div_b),
    .div_fin(div_fin), .div_q(div_q), .div_r(div_r), .div_err(div_err),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_q(s_out_q), .out_r(s_out_r),
    .out_err(s_out_err), .out_cycles(s_out_cycles)
  );

  // Divider stub: fin rises on the lat-th go cycle and stays high for hold_len
  // cycles after go falls.
  int lat = 1, hold_len = 0, sc = 0, hold = 0;

  assign div_fin = (div_go && sc >= lat - 1) || (hold != 0);
  assign div_err = (div_b == 8'd0);
  assign div_q   = (div_b == 8'd0) ? 8'hFF : div_a / div_b;
  assign div_r   = (div_b == 8'd0) ? div_a : div_a % div_b;

  always @(posedge clk) begin
    if (rst) begin
      sc   <= 0;
      hold <= 0;
    end else if (div_go) begin
      sc <= sc + 1;
      if (sc >= lat - 1) hold <= hold_len;
    end else begin
      sc <= 0;
      if (hold != 0) hold <= hold - 1;
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    logic [7:0] cyc;
  } exp_t;

  exp_t sb[$];
  int   ov_fin_bad = 0;

  // Scoreboard: pop and compare at every completed output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && div_fin) ov_fin_bad++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: got result q=%0d with no expected entry", out_q);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_q", out_q, e.q);
          check("out_r", out_r, e.r);
          check("out_err", out_err, e.err);
          check("out_cycles", out_cycles, e.cyc);
        end
      end
    end
  end

  task automatic launch(input logic [7:0] a, input logic [7:0] b, input int l, input int h);
    lat      = l;
    hold_len = h;
    @(posedge clk); #1;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int l, input int h,
                        output int go_n, output int drain_n, output int ov_n);
    bit done;
    launch(a, b, l, h);
    go_n = 0; drain_n = 0; ov_n = 0; done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (div_go) go_n++;
      else if (!out_valid && go_n > 0) drain_n++;
      if (out_valid) begin
        ov_n++;
        if (out_ready) done = 1;
      end
    end
    check("op_done", done, 1);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    int         hold;
    logic [7:0] q;
    logic [7:0] r;
    logic       err;
    logic [7:0] cyc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int go_n, drain_n, ov_n;
    logic [7:0] q0, r0, c0;

    vecs[0] = '{8'd100, 8'd7,   5, 0, 8'd14,  8'd2,  1'b0, 8'd5};
    vecs[1] = '{8'd42,  8'd0,   6, 0, 8'hFF,  8'd42, 1'b1, 8'd6};
    vecs[2] = '{8'd9,   8'd3,   3, 0, 8'd3,   8'd0,  1'b0, 8'd3};
    vecs[3] = '{8'd1,   8'd1,   1, 0, 8'd1,   8'd0,  1'b0, 8'd1};
    vecs[4] = '{8'd255, 8'd255, 2, 0, 8'd1,   8'd0,  1'b0, 8'd2};
    vecs[5] = '{8'd7,   8'd9,   3, 0, 8'd0,   8'd7,  1'b0, 8'd3};
    vecs[6] = '{8'd255, 8'd1,   8, 0, 8'd255, 8'd0,  1'b0, 8'd8};
    vecs[7] = '{8'd60,  8'd7,   4, 3, 8'd8,   8'd4,  1'b0, 8'd4};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_div_go", div_go, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_out_q", out_q, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_cycles", out_cycles, 0);

    // Table: basic ops, divide-by-zero followed by a clean op, latency 1, extended fin.
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{vecs[i].q, vecs[i].r, vecs[i].err, vecs[i].cyc});
      run_op(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold, go_n, drain_n, ov_n);
      check($sformatf("v%0d_go_cycles", i), go_n, vecs[i].lat);
      check($sformatf("v%0d_drain_cycles", i), drain_n, vecs[i].hold + 1);
      check($sformatf("v%0d_valid_cycles", i), ov_n, 1);
    end

    // Saturation: 20-cycle run reads 20 on the wide counter and 15 on the 4-bit one.
    sb.push_back('{8'd66, 8'd2, 1'b0, 8'd20});
    run_op(8'd200, 8'd3, 20, 0, go_n, drain_n, ov_n);
    check("sat_go_cycles", go_n, 20);
    check("sat_narrow_cycles", s_out_cycles, 15);
    check("sat_narrow_q", s_out_q, 66);
    check("sat_wide_cycles", out_cycles, 20);

    // Output back-pressure: result and handshake signals hold, in_valid ignored.
    out_ready = 1'b0;
    sb.push_back('{8'd7, 8'd7, 1'b0, 8'd3});
    launch(8'd77, 8'd10, 3, 0);
    for (int w = 0; w < 50 && !out_valid; w++) @(negedge clk);
    check("bp_valid", out_valid, 1);
    q0 = out_q; r0 = out_r; c0 = out_cycles;
    begin
      int bad = 0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        in_valid = i[0];
        in_a = 8'd5;
        in_b = 8'd1;
        @(negedge clk);
        if (!out_valid || in_ready || div_go || out_q !== q0 || out_r !== r0 ||
            out_cycles !== c0 || div_a !== 8'd77) bad++;
      end
      check("bp_stable_cycles_bad", bad, 0);
    end
    check("bp_q_held", q0, 8'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_valid", out_valid, 0);

    // Reset in the middle of a run.
    launch(8'd50, 8'd5, 10, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_div_go", div_go, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_q", out_q, 0);
    check("mid_rst_out_r", out_r, 0);
    check("mid_rst_out_cycles", out_cycles, 0);
    check("mid_rst_div_a", div_a, 0);
    sb.push_back('{8'd15, 8'd15, 1'b0, 8'd4});
    run_op(8'd255, 8'd16, 4, 0, go_n, drain_n, ov_n);
    check("post_rst_go_cycles", go_n, 4);

    check("valid_while_fin", ov_fin_bad, 0);
    check("sb_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
